// File: rtl/debouncer_2_pkg.sv
// Shared types for the debouncer_2 slice: the per-cycle decision taken by the
// stability counter, kept as a named enum so it is easy to probe in simulation.
package debouncer_2_pkg;

    typedef enum logic [1:0] {
        CNT_CLEAR  = 2'd0,  // synchronized level matches the output
        CNT_INC    = 2'd1,  // mismatch, window not yet complete
        CNT_ACCEPT = 2'd2   // mismatch held for the full window
    } cnt_act_e;

endpackage : debouncer_2_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Both stages reset to RST_VAL so the idle pin level is seen during reset.
module sync_2ff #(
    parameter bit RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule : sync_2ff

// File: rtl/debouncer_2.sv
// Switch debouncer: the output follows the synchronized input only after it has
// disagreed with the output for 2**N_THRESH consecutive clock edges.
module debouncer_2
    import debouncer_2_pkg::*;
#(
    parameter int N_THRESH  = 4,
    parameter bit IS_PULLUP = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_sig,
    output logic o_sig_debounced
);

    logic                s2;
    logic [N_THRESH-1:0] cnt;
    logic [N_THRESH-1:0] cnt_nxt;
    logic                out_nxt;
    cnt_act_e            act;

    sync_2ff #(
        .RST_VAL (IS_PULLUP)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (i_sig),
        .q    (s2)
    );

    // Any cycle where s2 agrees with the output restarts the window.
    always_comb begin
        act = CNT_CLEAR;
        if (s2 != o_sig_debounced) begin
            if (cnt == {N_THRESH{1'b1}}) begin
                act = CNT_ACCEPT;
            end else begin
                act = CNT_INC;
            end
        end
    end

    always_comb begin
        cnt_nxt = '0;
        out_nxt = o_sig_debounced;
        case (act)
            CNT_INC: begin
                cnt_nxt = cnt + 1'b1;
            end
            CNT_ACCEPT: begin
                out_nxt = s2;
            end
            default: begin
                cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt             <= '0;
            o_sig_debounced <= IS_PULLUP;
        end else begin
            cnt             <= cnt_nxt;
            o_sig_debounced <= out_nxt;
        end
    end

endmodule : debouncer_2

// File: tb/tb_debouncer_2.sv
// Directed bench for debouncer_2: a pulled-up and a pulled-down instance,
// both with a 16-cycle stability window.
module tb_debouncer_2;

    logic clk = 1'b0;
    logic rstn;
    logic i_sig;
    logic i_sig_pd;
    logic o_pu;
    logic o_pd;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    debouncer_2 #(
        .N_THRESH  (4),
        .IS_PULLUP (1'b1)
    ) dut_pu (
        .clk             (clk),
        .rstn            (rstn),
        .i_sig           (i_sig),
        .o_sig_debounced (o_pu)
    );

    debouncer_2 #(
        .N_THRESH  (4),
        .IS_PULLUP (1'b0)
    ) dut_pd (
        .clk             (clk),
        .rstn            (rstn),
        .i_sig           (i_sig_pd),
        .o_sig_debounced (o_pd)
    );

    // Advance one rising edge, then settle before looking at outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    initial begin
        rstn     = 1'b0;
        i_sig    = 1'b0;
        i_sig_pd = 1'b0;

        // Reset with the pin driven opposite to the pull-up level.
        repeat (10) begin
            tick();
            chk("reset_pu", o_pu, 1'b1);
            chk("reset_pd", o_pd, 1'b0);
        end

        // Stale synchronizer contents: the pulled-up output falls 17 edges
        // after the first post-release edge samples the 0.
        rstn = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            chk("release_pu", o_pu, (k < 18) ? 1'b1 : 1'b0);
            chk("release_pd", o_pd, 1'b0);
        end

        // Pull-down instance: clean step to 1.
        i_sig_pd = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            chk("pd_step", o_pd, (k < 18) ? 1'b0 : 1'b1);
        end

        // Short hold rejected, output at 0.
        repeat (10) begin
            i_sig = ~i_sig;
            tick();
            chk("short_bounce1", o_pu, 1'b0);
        end
        i_sig = 1'b1;
        repeat (5) begin
            tick();
            chk("short_hold5", o_pu, 1'b0);
        end
        repeat (10) begin
            i_sig = ~i_sig;
            tick();
            chk("short_bounce2", o_pu, 1'b0);
        end
        i_sig = 1'b0;
        repeat (20) begin
            tick();
            chk("short_settle0", o_pu, 1'b0);
        end

        // Fifteen stable cycles is one short of the window.
        i_sig = 1'b1;
        repeat (15) begin
            tick();
            chk("hold15", o_pu, 1'b0);
        end
        i_sig = 1'b0;
        repeat (20) begin
            tick();
            chk("hold15_drop", o_pu, 1'b0);
        end

        // Sixteen stable cycles completes the window.
        i_sig = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("hold16", o_pu, 1'b0);
        end
        i_sig = 1'b0;
        tick();
        chk("hold16_e16", o_pu, 1'b0);
        tick();
        chk("hold16_e17", o_pu, 1'b1);
        i_sig = 1'b1;
        repeat (20) begin
            tick();
            chk("hold16_after", o_pu, 1'b1);
        end

        // Bounce then settle high: output already 1 and must not glitch.
        repeat (10) begin
            i_sig = ~i_sig;
            tick();
            chk("bounce_high", o_pu, 1'b1);
        end
        repeat (30) begin
            tick();
            chk("settle_high", o_pu, 1'b1);
        end

        // High-side rejection, then bounce and settle low.
        repeat (10) begin
            i_sig = ~i_sig;
            tick();
            chk("hi_bounce1", o_pu, 1'b1);
        end
        i_sig = 1'b0;
        repeat (5) begin
            tick();
            chk("hi_hold5", o_pu, 1'b1);
        end
        repeat (9) begin
            i_sig = ~i_sig;
            tick();
            chk("hi_bounce2", o_pu, 1'b1);
        end
        i_sig = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            chk("settle_low", o_pu, (k < 18) ? 1'b1 : 1'b0);
        end

        // Reset mid-count returns the output to the pull-up level.
        i_sig = 1'b1;
        repeat (10) begin
            tick();
            chk("pre_rst_count", o_pu, 1'b0);
        end
        rstn  = 1'b0;
        i_sig = 1'b0;
        repeat (2) begin
            tick();
            chk("rst_mid1", o_pu, 1'b1);
        end
        rstn = 1'b1;
        repeat (10) begin
            tick();
            chk("post_rst_count", o_pu, 1'b1);
        end
        rstn = 1'b0;
        repeat (2) begin
            tick();
            chk("rst_mid2", o_pu, 1'b1);
        end
        rstn = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            chk("rst_full_window", o_pu, (k < 18) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_debouncer_2
